// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the shared step-adder arbiter.
//   ADDR_W / STEP_W : operand widths of the shared adder (8-bit base, 3-bit step).
//   MAX_REQ         : largest supported requester count; rr_pick works on this width.
//   rr_pick         : round-robin one-hot pick starting at ptr, wrapping at nreq.
package adder_arb_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned MAX_REQ = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [STEP_W-1:0] step_t;

    // Returns a one-hot vector with the first set bit of valid at or above ptr,
    // wrapping from nreq-1 back to 0. Bits at or above nreq are never granted.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [2:0]         ptr,
                                                   input int unsigned        nreq);
        logic [MAX_REQ-1:0] gnt;
        logic [2:0]         idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 3'((32'(ptr) + k) % nreq);
            if (k < nreq && !found && valid[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Bundle between the requesting stages / result consumer and the arbiter.
//   req_valid/req_a/req_b : per-requester operation (packed, requester i at slice i).
//   req_ready             : one-hot grant back to the requesters.
//   res_valid/res_ready   : result slot handshake.
//   res_y/res_carry/res_id: registered sum, carry out and owning requester.
// master = requester/consumer side, slave = arbiter side.
interface adder_share_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) ();

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_a;
    logic [NREQ*STEP_W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic                   res_ready;
    addr_t                  res_y;
    logic                   res_carry;
    logic [IDW-1:0]         res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_y, res_carry, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_y, res_carry, res_id
    );

endinterface

// File: rtl/step_adder8.sv
// Combinational 8-bit + 3-bit step adder.
//   a_i     : 8-bit base operand.
//   b_i     : 3-bit step, zero-extended.
//   y_o     : (a_i + b_i) mod 256.
//   carry_o : carry out of bit 7.
module step_adder8
    import adder_arb_pkg::*;
(
    input  addr_t a_i,
    input  step_t b_i,
    output addr_t y_o,
    output logic  carry_o
);

    assign {carry_o, y_o} = (ADDR_W + 1)'(a_i) + (ADDR_W + 1)'(b_i);

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one step adder between NREQ requesters, with a
// single-entry registered result slot.
//   clk   : rising-edge clock.
//   rst_n : synchronous active-low reset; also gates all grants while low.
//   bus   : requester operands/grants and result slot handshake (slave side).
// A full slot that is being drained this cycle counts as free, so accepts can
// run back to back at one per cycle.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);

    logic           res_valid_q, res_valid_d;
    addr_t          res_y_q, res_y_d;
    logic           res_carry_q, res_carry_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic               slot_free;
    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] pick;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_idx;
    addr_t              a_sel;
    step_t              b_sel;
    addr_t              sum_y;
    logic               sum_carry;
    logic               unused_pick;

    assign slot_free = !res_valid_q || bus.res_ready;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = bus.req_valid;
    end

    assign pick        = rr_pick(valid_ext, 3'(rr_ptr_q), NREQ);
    // Bits above NREQ are always zero; fold them so nothing is left dangling.
    assign unused_pick = ^pick;
    assign grant       = (rst_n && slot_free) ? pick[NREQ-1:0] : '0;

    // Operand mux and index encode driven by the one-hot grant.
    always_comb begin
        grant_idx = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDW'(i);
                a_sel     = bus.req_a[ADDR_W*i +: ADDR_W];
                b_sel     = bus.req_b[STEP_W*i +: STEP_W];
            end
        end
    end

    step_adder8 u_step_adder8 (
        .a_i     (a_sel),
        .b_i     (b_sel),
        .y_o     (sum_y),
        .carry_o (sum_carry)
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_carry_d = res_carry_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (|grant) begin
            res_valid_d = 1'b1;
            res_y_d     = sum_y;
            res_carry_d = sum_carry;
            res_id_d    = grant_idx;
            rr_ptr_d    = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
        end else if (res_valid_q && bus.res_ready) begin
            // Drain only; payload holds its last value.
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_carry_q <= res_carry_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = res_valid_q;
    assign bus.res_y     = res_y_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios followed by
// randomized traffic, all checked each cycle against a behavioural model.
module tb_adder_share_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the result slot and round-robin pointer.
    int       m_valid;
    int       m_y;
    int       m_carry;
    int       m_id;
    int       m_ptr;
    int       m_gnt;

    logic [NREQ-1:0] hold;

    adder_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_if ();

    adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [2:0] b);
        bus_if.req_valid[i]     = v;
        bus_if.req_a[8*i +: 8]  = a;
        bus_if.req_b[3*i +: 3]  = b;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int               g;
        int               idx;
        logic [NREQ-1:0]  exp_ready;
        int               sum;
        @(negedge clk);
        g = -1;
        if (rst_n && (m_valid == 0 || bus_if.res_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && bus_if.req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(bus_if.req_ready), 32'(exp_ready));
        chk("res_valid", 32'(bus_if.res_valid), m_valid);
        chk("res_y",     32'(bus_if.res_y),     m_y);
        chk("res_carry", 32'(bus_if.res_carry), m_carry);
        chk("res_id",    32'(bus_if.res_id),    m_id);
        @(posedge clk);
        m_gnt = g;
        if (!rst_n) begin
            m_valid = 0; m_y = 0; m_carry = 0; m_id = 0; m_ptr = 0; m_gnt = -1;
        end else if (g >= 0) begin
            sum     = int'(bus_if.req_a[8*g +: 8]) + int'(bus_if.req_b[3*g +: 3]);
            m_valid = 1;
            m_y     = sum % 256;
            m_carry = sum / 256;
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
        end else if (m_valid != 0 && bus_if.res_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        m_valid = 0; m_y = 0; m_carry = 0; m_id = 0; m_ptr = 0; m_gnt = -1;
        rst_n            = 1'b0;
        bus_if.res_ready = 1'b1;
        set_req(0, 1'b1, 8'h10, 3'd3);
        set_req(1, 1'b1, 8'h40, 3'd2);
        @(posedge clk);
        #1;

        // Reset held with both requesters valid: no grants, slot empty.
        step();
        step();

        // First grant after release goes to requester 0.
        rst_n = 1'b1;
        step();
        chk("single_y",   32'(bus_if.res_y),     32'h13);
        chk("single_id",  32'(bus_if.res_id),    32'h0);
        chk("single_cy",  32'(bus_if.res_carry), 32'h0);

        // Contention: grants alternate with no bubbles.
        set_req(0, 1'b1, 8'h20, 3'd1);
        set_req(1, 1'b1, 8'h40, 3'd2);
        for (int n = 0; n < 4; n++) step();
        chk("rr_valid", 32'(bus_if.res_valid), 32'h1);

        // Backpressure for 3 cycles, then drain and re-grant in the same cycle.
        bus_if.res_ready = 1'b0;
        for (int n = 0; n < 3; n++) step();
        bus_if.res_ready = 1'b1;
        step();

        // Wrap-around and zero-step cases.
        set_req(1, 1'b0, 8'h00, 3'd0);
        set_req(0, 1'b1, 8'hFF, 3'd1);
        step();
        chk("wrap_y",  32'(bus_if.res_y),     32'h00);
        chk("wrap_cy", 32'(bus_if.res_carry), 32'h1);
        set_req(0, 1'b1, 8'hFD, 3'd7);
        step();
        chk("wrap2_y",  32'(bus_if.res_y),     32'h04);
        chk("wrap2_cy", 32'(bus_if.res_carry), 32'h1);
        set_req(0, 1'b1, 8'hFF, 3'd7);
        step();
        chk("max_y",  32'(bus_if.res_y),     32'h06);
        chk("max_cy", 32'(bus_if.res_carry), 32'h1);
        set_req(0, 1'b1, 8'h55, 3'd0);
        step();
        chk("zero_y",  32'(bus_if.res_y),     32'h55);
        chk("zero_cy", 32'(bus_if.res_carry), 32'h0);

        // Reset while a result is stalled: it must vanish and ptr returns to 0.
        set_req(1, 1'b1, 8'h80, 3'd5);
        step();
        bus_if.res_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus_if.res_ready = 1'b1;
        set_req(0, 1'b0, 8'h00, 3'd0);
        set_req(1, 1'b0, 8'h00, 3'd0);
        step();
        chk("rst_mid_valid", 32'(bus_if.res_valid), 32'h0);
        set_req(0, 1'b1, 8'h01, 3'd1);
        set_req(1, 1'b1, 8'h02, 3'd2);
        step();
        chk("rst_mid_id", 32'(bus_if.res_id), 32'h0);

        // Randomized traffic; a raised request holds until granted.
        hold = '0;
        set_req(0, 1'b0, 8'h00, 3'd0);
        set_req(1, 1'b0, 8'h00, 3'd0);
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt == i) hold[i] = 1'b0;
                if (!hold[i] && ($urandom_range(0, 1) == 1)) begin
                    hold[i] = 1'b1;
                    set_req(i, 1'b1, 8'($urandom), 3'($urandom));
                end else if (!hold[i]) begin
                    set_req(i, 1'b0, 8'($urandom), 3'($urandom));
                end
            end
            bus_if.res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
